// File: rtl/ocu_weight_bank_ctrl_pkg.sv
// Shared OCU enums and helpers.
// Holds the pooling mode enum used elsewhere in the OCU and the weight bank
// controller state type. It also provides the helper that maps a
// (block, line, column) save-enable coordinate to its position in the
// weight word stream.
package ocu_weight_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    POOL_NONE,
    POOL_MAX,
    POOL_AVG
  } pooling_type_e;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    LOAD,
    FULL
  } weight_ctrl_state;

  localparam int unsigned DEF_N_I            = 512;
  localparam int unsigned DEF_K              = 3;
  localparam int unsigned DEF_WEIGHT_STAGGER = 8;

  // The stream runs block-fastest, then column, then line:
  // i = (line*K + column)*WS + block
  function automatic int unsigned word_index(input int unsigned block,
                                             input int unsigned line,
                                             input int unsigned column,
                                             input int unsigned ws,
                                             input int unsigned k);
    return (line * k + column) * ws + block;
  endfunction

endpackage

// File: rtl/ocu_weight_bank_ctrl_weight_index_decoder.sv
// Weight index decoder.
// Turns the running word counter into a one-hot save enable over the
// [block][line][column] latch grid. The decoder is purely combinational.
// Ports:
//   strobe      in   1                    a word is accepted this cycle
//   word_idx    in   CNT_WIDTH            index of the word being accepted
//   save_enable out  [0:WS-1][0:K-1][0:K-1] one-hot (all zero when !strobe)
module ocu_weight_bank_ctrl_weight_index_decoder
  import ocu_weight_bank_ctrl_pkg::*;
#(
  parameter int unsigned K         = 3,
  parameter int unsigned WS        = 8,
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic                              strobe,
  input  logic [CNT_WIDTH-1:0]              word_idx,
  output logic [0:WS-1][0:K-1][0:K-1]       save_enable
);

  for (genvar gi = 0; gi < WS; gi++) begin : g_block
    for (genvar gl = 0; gl < K; gl++) begin : g_line
      for (genvar gc = 0; gc < K; gc++) begin : g_col
        localparam int unsigned IDX = word_index(gi, gl, gc, WS, K);
        assign save_enable[gi][gl][gc] = strobe && (word_idx == CNT_WIDTH'(IDX));
      end
    end
  end

endmodule

// File: rtl/ocu_weight_bank_ctrl.sv
// OCU weight bank controller.
// Sequences kernel loading into the shadow half of the double-buffered weight
// banks. On a load request it first flushes the shadow bank for one cycle.
// It then accepts NUM_WORDS weight words over valid/ready and strobes one save
// enable per accepted word. A swap request on a fully loaded shadow bank makes
// that bank the active (read) bank.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   load_start_i            start loading a new kernel into the shadow bank
//   abort_i                 cancel any activity, invalidate shadow bank
//   weights_valid_i/ready_o word handshake (data itself goes straight to the OCU)
//   swap_req_i/swap_ack_o   level swap request / same-cycle acknowledge
//   testmode_i              forces all latch test enables
//   weights_read_bank_o     active bank; weights_save_bank_o is its complement
//   weights_save_enable_o   one-hot save strobe per accepted word
//   weights_test_enable_o   all ones in test mode
//   weights_flush_o         flush of the shadow bank
//   shadow_valid_o          shadow bank holds a complete kernel
//   load_done_o             pulse in the cycle after the last word was accepted
//   busy_o                  flushing or loading
module ocu_weight_bank_ctrl
  import ocu_weight_bank_ctrl_pkg::*;
#(
  parameter int unsigned N_I            = DEF_N_I,
  parameter int unsigned K              = DEF_K,
  parameter int unsigned WEIGHT_STAGGER = DEF_WEIGHT_STAGGER
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          load_start_i,
  input  logic                                          abort_i,
  input  logic                                          weights_valid_i,
  output logic                                          weights_ready_o,
  input  logic                                          swap_req_i,
  output logic                                          swap_ack_o,
  input  logic                                          testmode_i,
  output logic                                          weights_read_bank_o,
  output logic                                          weights_save_bank_o,
  output logic [0:WEIGHT_STAGGER-1][0:K-1][0:K-1]       weights_save_enable_o,
  output logic [0:WEIGHT_STAGGER-1][0:K-1][0:K-1]       weights_test_enable_o,
  output logic [0:WEIGHT_STAGGER-1]                     weights_flush_o,
  output logic                                          shadow_valid_o,
  output logic                                          load_done_o,
  output logic                                          busy_o
);

  localparam int unsigned NUM_WORDS = K * K * WEIGHT_STAGGER;
  localparam int unsigned CNT_WIDTH = $clog2(NUM_WORDS);
  localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(NUM_WORDS - 1);

  // A word carries N_I/WEIGHT_STAGGER weights, so the split has to be exact.
  if ((N_I % WEIGHT_STAGGER) != 0) begin : g_bad_stagger
    $error("N_I must be divisible by WEIGHT_STAGGER");
  end

  weight_ctrl_state       state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                   read_bank_reg, read_bank_next;
  logic                   shadow_valid_reg, shadow_valid_next;
  logic                   load_done_reg, load_done_next;
  logic                   word_accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      read_bank_reg    <= 1'b0;
      shadow_valid_reg <= 1'b0;
      load_done_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      read_bank_reg    <= read_bank_next;
      shadow_valid_reg <= shadow_valid_next;
      load_done_reg    <= load_done_next;
    end
  end

  // Abort blocks acceptance, so no save enable can fire in the abort cycle.
  assign weights_ready_o = (state_reg == LOAD) && !abort_i;
  assign word_accept     = weights_ready_o && weights_valid_i;
  assign swap_ack_o      = (state_reg == FULL) && swap_req_i && !abort_i;
  assign weights_flush_o = (state_reg == FLUSH) ? '1 : '0;
  assign busy_o          = (state_reg == FLUSH) || (state_reg == LOAD);

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    read_bank_next    = read_bank_reg;
    shadow_valid_next = shadow_valid_reg;
    load_done_next    = 1'b0;

    if (abort_i) begin
      state_next        = IDLE;
      cnt_next          = '0;
      shadow_valid_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load_start_i) state_next = FLUSH;
        end
        FLUSH: begin
          cnt_next   = '0;
          state_next = LOAD;
        end
        LOAD: begin
          if (word_accept) begin
            if (cnt_reg == LAST_WORD) begin
              cnt_next          = '0;
              shadow_valid_next = 1'b1;
              load_done_next    = 1'b1;
              state_next        = FULL;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        FULL: begin
          if (swap_req_i) begin
            read_bank_next    = !read_bank_reg;
            shadow_valid_next = 1'b0;
            // The bank that was active becomes the shadow and may be refilled at once.
            state_next        = load_start_i ? FLUSH : IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  ocu_weight_bank_ctrl_weight_index_decoder #(
    .K         (K),
    .WS        (WEIGHT_STAGGER),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_index_decoder (
    .strobe      (word_accept),
    .word_idx    (cnt_reg),
    .save_enable (weights_save_enable_o)
  );

  assign weights_test_enable_o = testmode_i ? '1 : '0;
  assign weights_read_bank_o   = read_bank_reg;
  assign weights_save_bank_o   = !read_bank_reg;
  assign shadow_valid_o        = shadow_valid_reg;
  assign load_done_o           = load_done_reg;

endmodule

// File: tb/tb_ocu_weight_bank_ctrl.sv
module tb_ocu_weight_bank_ctrl;

  localparam int K  = 3;
  localparam int WS = 8;
  localparam int NW = K * K * WS;

  localparam int M_IDLE  = 0;
  localparam int M_FLUSH = 1;
  localparam int M_LOAD  = 2;
  localparam int M_FULL  = 3;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic load_start_i = 1'b0;
  logic abort_i = 1'b0;
  logic weights_valid_i = 1'b0;
  logic swap_req_i = 1'b0;
  logic testmode_i = 1'b0;
  logic weights_ready_o, swap_ack_o, weights_read_bank_o, weights_save_bank_o;
  logic [0:WS-1][0:K-1][0:K-1] weights_save_enable_o, weights_test_enable_o;
  logic [0:WS-1] weights_flush_o;
  logic shadow_valid_o, load_done_o, busy_o;

  ocu_weight_bank_ctrl #(.N_I(512), .K(K), .WEIGHT_STAGGER(WS)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .load_start_i          (load_start_i),
    .abort_i               (abort_i),
    .weights_valid_i       (weights_valid_i),
    .weights_ready_o       (weights_ready_o),
    .swap_req_i            (swap_req_i),
    .swap_ack_o            (swap_ack_o),
    .testmode_i            (testmode_i),
    .weights_read_bank_o   (weights_read_bank_o),
    .weights_save_bank_o   (weights_save_bank_o),
    .weights_save_enable_o (weights_save_enable_o),
    .weights_test_enable_o (weights_test_enable_o),
    .weights_flush_o       (weights_flush_o),
    .shadow_valid_o        (shadow_valid_o),
    .load_done_o           (load_done_o),
    .busy_o                (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase, words accepted so far, active bank, cycles spent full.
  int m_mode = M_IDLE;
  int m_words = 0;
  int m_rb = 0;
  int m_full_age = 0;

  bit chk_on = 1'b0;
  bit first_load = 1'b0;

  // Running totals observed on the DUT, read by the stimulus as differences.
  int flush_tot = 0;
  int done_tot = 0;
  int ack_tot = 0;
  int pulse_tot = 0;
  int hit[NW];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Model update on the clock, reset asynchronously.
  initial begin
    for (int i = 0; i < NW; i++) hit[i] = 0;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_mode = M_IDLE; m_words = 0; m_rb = 0; m_full_age = 0;
      end else if (abort_i) begin
        m_mode = M_IDLE; m_words = 0;
      end else begin
        case (m_mode)
          M_IDLE:  if (load_start_i) m_mode = M_FLUSH;
          M_FLUSH: begin m_mode = M_LOAD; m_words = 0; end
          M_LOAD: begin
            if (weights_valid_i) begin
              m_words++;
              if (m_words == NW) begin
                m_mode = M_FULL; m_words = 0; m_full_age = 0;
              end
            end
          end
          default: begin
            m_full_age++;
            if (swap_req_i) begin
              m_rb = 1 - m_rb;
              m_mode = load_start_i ? M_FLUSH : M_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Compare process: every cycle, mid-period.
  logic [0:WS-1][0:K-1][0:K-1] exp_en;
  bit exp_ready, acc;
  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_on) begin
        exp_ready = (m_mode == M_LOAD) && !abort_i && rst_ni;
        acc = exp_ready && weights_valid_i;
        exp_en = '0;
        if (acc) exp_en[m_words % WS][m_words / (WS * K)][(m_words / WS) % K] = 1'b1;
        chk("ready", weights_ready_o, exp_ready);
        chk("flush", weights_flush_o, (m_mode == M_FLUSH) ? 8'hFF : 8'h00);
        chk("busy", busy_o, (m_mode == M_FLUSH) || (m_mode == M_LOAD));
        chk("read_bank", weights_read_bank_o, m_rb[0]);
        chk("save_bank", weights_save_bank_o, !m_rb[0]);
        chk("shadow_valid", shadow_valid_o, m_mode == M_FULL);
        chk("load_done", load_done_o, (m_mode == M_FULL) && (m_full_age == 0));
        chk("swap_ack", swap_ack_o, (m_mode == M_FULL) && swap_req_i && !abort_i);
        chk("save_enable", weights_save_enable_o, exp_en);
        chk("test_enable", weights_test_enable_o, testmode_i ? {72{1'b1}} : 72'd0);
        if (first_load && acc && m_words == 0) chk("word0_en000", weights_save_enable_o[0][0][0], 1'b1);
        if (first_load && acc && m_words == 8) chk("word8_en001", weights_save_enable_o[0][0][1], 1'b1);
        if (first_load && acc && m_words == 71) chk("word71_en722", weights_save_enable_o[7][2][2], 1'b1);
        if (weights_flush_o != '0) flush_tot++;
        if (load_done_o) done_tot++;
        if (swap_ack_o) ack_tot++;
        for (int b = 0; b < WS; b++)
          for (int l = 0; l < K; l++)
            for (int c = 0; c < K; c++)
              if (weights_save_enable_o[b][l][c]) begin
                hit[(l * K + c) * WS + b]++;
                pulse_tot++;
              end
      end
    end
  end

  task automatic wait_full(input string name, input int limit);
    int i;
    i = 0;
    while (shadow_valid_o !== 1'b1 && i < limit) begin
      tick();
      i++;
    end
    chk(name, shadow_valid_o, 1'b1);
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int f0, d0, a0, p0, bad, i;
  int hit0[NW];

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk_on = 1'b1;
    @(negedge clk_i);
    #1;
    chk("rst_read_bank", weights_read_bank_o, 1'b0);
    chk("rst_save_bank", weights_save_bank_o, 1'b1);
    chk("rst_ready", weights_ready_o, 1'b0);
    chk("rst_flush", weights_flush_o, 8'h00);
    chk("rst_shadow", shadow_valid_o, 1'b0);
    chk("rst_enables", weights_save_enable_o, 72'd0);
    $display("reset: read_bank=%0d save_bank=%0d", weights_read_bank_o, weights_save_bank_o);

    // Back-to-back load.
    tick();
    f0 = flush_tot; d0 = done_tot; p0 = pulse_tot;
    first_load = 1'b1;
    weights_valid_i = 1'b1;
    start_load();
    wait_full("load1_full", 200);
    weights_valid_i = 1'b0;
    first_load = 1'b0;
    tick();
    chk("load1_flush_cycles", flush_tot - f0, 1);
    chk("load1_done_pulses", done_tot - d0, 1);
    chk("load1_pulses", pulse_tot - p0, 72);
    chk("load1_shadow", shadow_valid_o, 1'b1);
    $display("load back-to-back: words=%0d flush_cycles=%0d", pulse_tot - p0, flush_tot - f0);

    // Swap and load_start together in FULL.
    swap_req_i = 1'b1;
    load_start_i = 1'b1;
    #1;
    chk("swapload_ack", swap_ack_o, 1'b1);
    tick();
    swap_req_i = 1'b0;
    load_start_i = 1'b0;
    #1;
    chk("swapload_flush", weights_flush_o, 8'hFF);
    chk("swapload_read_bank", weights_read_bank_o, 1'b1);
    chk("swapload_save_bank", weights_save_bank_o, 1'b0);
    $display("swap+load: read_bank=%0d flush=%h", weights_read_bank_o, weights_flush_o);

    // Load with random valid gaps.
    hit0 = hit;
    p0 = pulse_tot;
    i = 0;
    while (shadow_valid_o !== 1'b1 && i < 1500) begin
      weights_valid_i = ($urandom_range(0, 99) >= 30);
      tick();
      i++;
    end
    weights_valid_i = 1'b0;
    chk("gap_full", shadow_valid_o, 1'b1);
    chk("gap_pulses", pulse_tot - p0, 72);
    bad = 0;
    for (int w = 0; w < NW; w++) if (hit[w] - hit0[w] != 1) bad++;
    chk("gap_each_once", bad, 0);
    $display("load with gaps: words=%0d cycles=%0d", pulse_tot - p0, i);

    // Plain swap back to bank 0, then swap_req held from IDLE across a load.
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    chk("swap_back_read_bank", weights_read_bank_o, 1'b0);
    a0 = ack_tot;
    swap_req_i = 1'b1;
    weights_valid_i = 1'b1;
    start_load();
    wait_full("held_full", 200);
    weights_valid_i = 1'b0;
    repeat (4) tick();
    swap_req_i = 1'b0;
    chk("held_ack_pulses", ack_tot - a0, 1);
    chk("held_read_bank", weights_read_bank_o, 1'b1);
    chk("held_save_bank", weights_save_bank_o, 1'b0);
    $display("held swap: acks=%0d read_bank=%0d", ack_tot - a0, weights_read_bank_o);

    // Abort at word 40.
    weights_valid_i = 1'b1;
    start_load();
    i = 0;
    while (!(m_mode == M_LOAD && m_words == 40) && i < 200) begin
      tick();
      i++;
    end
    chk("abort_reach40", m_words, 40);
    p0 = pulse_tot;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (10) tick();
    chk("abort_no_enables", pulse_tot - p0, 0);
    chk("abort_shadow", shadow_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_read_bank", weights_read_bank_o, 1'b1);
    start_load();
    wait_full("after_abort_full", 200);
    weights_valid_i = 1'b0;
    chk("after_abort_read_bank", weights_read_bank_o, 1'b1);
    $display("abort at word 40: reload full=%0d read_bank=%0d", shadow_valid_o, weights_read_bank_o);

    // Test mode.
    testmode_i = 1'b1;
    #1;
    chk("testmode_on", weights_test_enable_o, {72{1'b1}});
    repeat (2) tick();
    testmode_i = 1'b0;
    #1;
    chk("testmode_off", weights_test_enable_o, 72'd0);
    $display("testmode: toggled");

    // Reset in the middle of a load.
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    weights_valid_i = 1'b1;
    start_load();
    i = 0;
    while (!(m_mode == M_LOAD && m_words == 10) && i < 200) begin
      tick();
      i++;
    end
    rst_ni = 1'b0;
    weights_valid_i = 1'b0;
    #1;
    chk("midrst_read_bank", weights_read_bank_o, 1'b0);
    chk("midrst_shadow", shadow_valid_o, 1'b0);
    chk("midrst_ready", weights_ready_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("midrst_idle_shadow", shadow_valid_o, 1'b0);
    $display("reset mid-load: read_bank=%0d shadow=%0d", weights_read_bank_o, shadow_valid_o);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
